wait_sched: RTL
===============

// Module: wait_sched
// PURPOSE
//  Round-robin scheduler sharing one wait_fsm timer among N requesters.
//  Picks a requester, pulses the timer's go, then waits for the timer's done
//  or the winner's cancel. Forwards completion to the winner as a one-cycle
//  done pulse, or kills the timer on cancel. Sits between client FSMs and a
//  single wait_fsm instance (go/kill/idle/done).
// PARAMETERS
//  N            4     number of requesters (2..16)
//  WDOG_CYCLES  64    RUN-state watchdog limit in cycles (WAIT_SCHED_WDOG_EN only)
// PORTS
//  clk       in   1  clock; all state on rising edge
//  reset     in   1  asynchronous, active-low reset (0 = reset asserted)
//  req       in   N  per-requester request; level, held until done/cancel
//  cancel    in   N  per-requester abort; only cancel[owner] is honoured
//  grant     out  N  one-hot owner of the timer; 0 when unowned
//  done_out  out  N  one-cycle pulse on the owner's bit when its wait completes
//  tmr_go    out  1  to wait_fsm go; one-cycle pulse
//  tmr_kill  out  1  to wait_fsm kill; level
//  tmr_idle  in   1  from wait_fsm idle
//  tmr_done  in   1  from wait_fsm done
//  wdog_err  out  1  one-cycle pulse on watchdog kill; constant 0 if feature off
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, grant=0, done_out=0, tmr_go=0,
//   tmr_kill=0, wdog_err=0, rr pointer=0, wdog counter=0. Takes effect
//   mid-operation; the timer is not killed explicitly (it shares the reset).
//  All outputs are registered.
//  FSM:
//   IDLE : if tmr_idle=1 and |req: winner = first set req at or after ptr
//          (wrapping N-1 -> 0); grant<=onehot(winner); -> START.
//          If tmr_idle=0, no grant is issued (wait).
//   START: tmr_go=1 for exactly this one cycle; -> RUN.
//   RUN  : tmr_done=1 -> done_out[owner]=1 next cycle, grant<=0,
//          ptr<=owner+1 mod N, -> IDLE.
//          else cancel[owner]=1 -> KILL.
//          else (WDOG_EN) counter==WDOG_CYCLES-1 -> wdog_err pulse, -> KILL.
//   KILL : tmr_kill=1 held; when tmr_idle=1: tmr_kill<=0, grant<=0,
//          ptr<=owner+1 mod N, no done_out, -> IDLE. Minimum 1 kill cycle.
//  Latency: req in IDLE -> grant 1 clk -> tmr_go the following clk.
//   tmr_done -> done_out 1 clk. Re-grant no earlier than 1 clk after IDLE entry.
//  Boundaries:
//   tmr_done and cancel[owner] same cycle: done wins, done_out pulses.
//   cancel on non-owner bits: ignored. Owner dropping req without cancel:
//    ignored, wait runs to completion.
//   tmr_done outside RUN: ignored.
//   Single requester: re-granted back to back (ptr wrap lands on it).
//   ptr wraps N-1 -> 0; index width = clog2(N).
//   grant is one-hot or zero at all times; done_out at most one bit set.
// CONFIGURATION
//  WAIT_SCHED_WDOG_EN defined: counter (clog2(WDOG_CYCLES) bits) clears on
//   RUN entry and increments each RUN cycle; on reaching WDOG_CYCLES-1
//   without done/cancel -> wdog_err pulse + KILL path.
//  Not defined: no counter logic; wdog_err tied 0; RUN waits indefinitely.
// TESTING  (N=4, WDOG_CYCLES=16, 20 ns clock)
//  1 reset=0 mid-RUN (grant=4'b0010) -> same-cycle grant=0, tmr_go=0,
//    tmr_kill=0; after release, req=4'b0010 regranted, ptr restarted at 0.
//  2 req=4'b0001, tmr_done 5 clk after tmr_go -> done_out=4'b0001 for one clk,
//    grant=0; tmr_go exactly one cycle high.
//  3 req=4'b1111 held, each wait completed -> grant order 0001,0010,0100,
//    1000,0001 (round robin wrap).
//  4 owner 2, cancel=4'b0100 in RUN; tmr_idle returns 2 clk later ->
//    tmr_kill high 2 clk, no done_out, next grant=4'b1000 if req[3].
//  5 tmr_done and cancel[owner] same clk -> done_out pulses, tmr_kill stays 0;
//    cancel=4'b1000 while owner=0 -> no effect.
//  6 WDOG_EN, tmr_done never arrives -> wdog_err pulse 16 clk after RUN entry,
//    tmr_kill asserted; without WDOG_EN grant held >100 clk, wdog_err=0.

Source files
------------

// File: rtl/wait_sched.sv
// wait_sched: round-robin arbiter handing one shared wait_fsm timer to N requesters.
// Define WAIT_SCHED_WDOG_EN to add a RUN-state watchdog that kills a stuck wait.
module wait_sched #(
    parameter int unsigned N           = 4,
    parameter int unsigned WDOG_CYCLES = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic [N-1:0] cancel,
    output logic [N-1:0] grant,
    output logic [N-1:0] done_out,
    output logic         tmr_go,
    output logic         tmr_kill,
    input  logic         tmr_idle,
    input  logic         tmr_done,
    output logic         wdog_err
);
    localparam int unsigned IW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_KILL
    } state_t;

    state_t        state, state_n;
    logic [N-1:0]  grant_n, done_n;
    logic          go_n, kill_n;
    logic [IW-1:0] ptr, ptr_n, owner, owner_n;
    logic [IW-1:0] winner, cand, owner_inc;
    logic          found;

    if (N < 2 || N > 16 || WDOG_CYCLES < 2) begin : g_bad_params
        $error("wait_sched: unsupported N or WDOG_CYCLES");
    end

`ifdef WAIT_SCHED_WDOG_EN
    localparam int unsigned CW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
    logic [CW-1:0] cnt, cnt_n;
    logic          wdog_n;
`endif

    // First pending request at or after the rotating pointer.
    always_comb begin : pick_winner
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IW'((32'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign owner_inc = (owner == IW'(N - 1)) ? '0 : owner + IW'(1);

    always_comb begin : next_state
        state_n = state;
        grant_n = grant;
        owner_n = owner;
        ptr_n   = ptr;
        done_n  = '0;
        go_n    = 1'b0;
        kill_n  = tmr_kill;
`ifdef WAIT_SCHED_WDOG_EN
        cnt_n   = cnt;
        wdog_n  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                // A busy timer blocks new grants even if requests are pending.
                if (tmr_idle && found) begin
                    grant_n = N'(1) << winner;
                    owner_n = winner;
                    state_n = S_START;
                end
            end
            S_START: begin
                go_n    = 1'b1;
                state_n = S_RUN;
`ifdef WAIT_SCHED_WDOG_EN
                cnt_n   = '0;
`endif
            end
            S_RUN: begin
                // Completion takes priority over a same-cycle cancel.
                if (tmr_done) begin
                    done_n  = grant;
                    grant_n = '0;
                    ptr_n   = owner_inc;
                    state_n = S_IDLE;
                end else if (cancel[owner]) begin
                    kill_n  = 1'b1;
                    state_n = S_KILL;
`ifdef WAIT_SCHED_WDOG_EN
                end else if (cnt == CW'(WDOG_CYCLES - 1)) begin
                    wdog_n  = 1'b1;
                    kill_n  = 1'b1;
                    state_n = S_KILL;
                end else begin
                    cnt_n   = cnt + CW'(1);
`endif
                end
            end
            S_KILL: begin
                if (tmr_idle) begin
                    kill_n  = 1'b0;
                    grant_n = '0;
                    ptr_n   = owner_inc;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin : regs
        if (!reset) begin
            state    <= S_IDLE;
            grant    <= '0;
            done_out <= '0;
            tmr_go   <= 1'b0;
            tmr_kill <= 1'b0;
            ptr      <= '0;
            owner    <= '0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            done_out <= done_n;
            tmr_go   <= go_n;
            tmr_kill <= kill_n;
            ptr      <= ptr_n;
            owner    <= owner_n;
        end
    end

`ifdef WAIT_SCHED_WDOG_EN
    always_ff @(posedge clk or negedge reset) begin : wdog_regs
        if (!reset) begin
            cnt      <= '0;
            wdog_err <= 1'b0;
        end else begin
            cnt      <= cnt_n;
            wdog_err <= wdog_n;
        end
    end
`else
    assign wdog_err = 1'b0;
`endif

endmodule
